// File: rtl/lzc_norm_pipe_if.sv
// Valid/ready stream bundle for lzc_norm_pipe: mantissa and tag in; count, zero flag,
// normalised mantissa and tag out.
interface lzc_norm_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic             out_zero;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_cnt, out_zero, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_cnt, out_zero, out_data, out_tag
    );
endinterface

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero counter / normaliser with valid/ready flow control.
// Define LZC_NORM_SHIFT_EN to left-normalise out_data; otherwise out_data = in_data.
module lzc_norm_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    lzc_norm_pipe_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    // {nonzero, c[1], c[0]} for one nibble, MSB first
    function automatic logic [2:0] lzc4(input logic [3:0] a);
        lzc4 = {|a, ~(a[3] | a[2]), ~a[3] & (a[2] | ~a[1])};
    endfunction

`ifdef LZC_NORM_SHIFT_EN
    function automatic logic [WIDTH-1:0] barrel_shl(input logic [WIDTH-1:0] d,
                                                    input logic [SH_W-1:0]  sh);
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < SH_W; k++)
            if (sh[k]) r = r << (1 << k);
        return r;
    endfunction
`endif

    logic                  r_vld_p1;
    logic [WIDTH-1:0]      r_data_p1;
    logic [TAG_W-1:0]      r_tag_p1;
    logic [NIB-1:0][1:0]   r_ncnt_p1;
    logic [NIB-1:0]        r_nv_p1;

    logic                  r_vld_p2;
    logic [CNT_W-1:0]      r_cnt_p2;
    logic                  r_zero_p2;
    logic [WIDTH-1:0]      r_data_p2;
    logic [TAG_W-1:0]      r_tag_p2;

    logic                  w_s1_en;
    logic                  w_s2_en;
    logic [NIB-1:0][1:0]   w_ncnt;
    logic [NIB-1:0]        w_nv;
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_zero;
    logic [WIDTH-1:0]      w_data_s2;

    assign w_s2_en     = ~r_vld_p2 | bus.out_ready;
    assign w_s1_en     = ~r_vld_p1 | w_s2_en;
    assign bus.in_ready = w_s1_en;

    // Stage 0 -> S1: per-nibble count and nonzero flag (nibble 0 is the MSB nibble)
    always_comb begin
        w_ncnt = '0;
        w_nv   = '0;
        for (int g = 0; g < NIB; g++)
            {w_nv[g], w_ncnt[g]} = lzc4(bus.in_data[WIDTH-1-4*g -: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_tag_p1  <= '0;
            r_ncnt_p1 <= '0;
            r_nv_p1   <= '0;
        end else if (w_s1_en) begin
            r_vld_p1  <= bus.in_valid;
            r_data_p1 <= bus.in_data;
            r_tag_p1  <= bus.in_tag;
            r_ncnt_p1 <= w_ncnt;
            r_nv_p1   <= w_nv;
        end
    end

    // S1 -> S2: the last hit in a descending scan is the most-significant nonzero nibble
    always_comb begin
        w_cnt  = CNT_W'(WIDTH);
        w_zero = 1'b1;
        for (int g = NIB - 1; g >= 0; g--) begin
            if (r_nv_p1[g]) begin
                w_cnt  = CNT_W'(4 * g) + CNT_W'(r_ncnt_p1[g]);
                w_zero = 1'b0;
            end
        end
    end

`ifdef LZC_NORM_SHIFT_EN
    assign w_data_s2 = barrel_shl(r_data_p1, w_cnt[SH_W-1:0]);
`else
    assign w_data_s2 = r_data_p1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_cnt_p2  <= '0;
            r_zero_p2 <= 1'b0;
            r_data_p2 <= '0;
            r_tag_p2  <= '0;
        end else if (w_s2_en) begin
            r_vld_p2  <= r_vld_p1;
            r_cnt_p2  <= w_cnt;
            r_zero_p2 <= w_zero;
            r_data_p2 <= w_data_s2;
            r_tag_p2  <= r_tag_p1;
        end
    end

    // Stale contents of an empty output stage must never be visible
    assign bus.out_valid = r_vld_p2;
    assign bus.out_cnt   = r_vld_p2 ? r_cnt_p2  : '0;
    assign bus.out_zero  = r_vld_p2 ? r_zero_p2 : 1'b0;
    assign bus.out_data  = r_vld_p2 ? r_data_p2 : '0;
    assign bus.out_tag   = r_vld_p2 ? r_tag_p2  : '0;
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Randomised and directed bench for lzc_norm_pipe (WIDTH=32) against a bit-length based
// reference model with an in-order scoreboard.
module tb_lzc_norm_pipe;
    localparam int WIDTH = 32;
    localparam int TAG_W = 8;

    typedef struct {
        logic [5:0]  cnt;
        logic        zero;
        logic [31:0] data;
        logic [7:0]  tag;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];

    lzc_norm_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

    lzc_norm_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        else n_pass++;
    endtask

    // Count = WIDTH minus the bit length of the value; normalising shifts the top set bit to the MSB.
    function automatic exp_t model(input logic [31:0] d, input logic [7:0] t);
        exp_t m;
        longint unsigned x = {32'd0, d};
        int bl = 0;
        while ((x >> bl) != 0) bl++;
        m.cnt  = 6'(32 - bl);
        m.zero = (d == 0);
`ifdef LZC_NORM_SHIFT_EN
        m.data = 32'(x << m.cnt);
`else
        m.data = d;
`endif
        m.tag  = t;
        m.due  = 0;
        return m;
    endfunction

    task automatic check_outputs();
        bit exp_v;
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        check_eq("out_valid", bus.out_valid, exp_v);
        if (exp_v && bus.out_valid) begin
            check_eq("out_cnt",  bus.out_cnt,  q[0].cnt);
            check_eq("out_zero", bus.out_zero, q[0].zero);
            check_eq("out_data", bus.out_data, q[0].data);
            check_eq("out_tag",  bus.out_tag,  q[0].tag);
        end else if (!bus.out_valid) begin
            check_eq("idle_outs", {bus.out_cnt, bus.out_zero, bus.out_data, bus.out_tag}, '0);
        end
    endtask

    // One clock: check state after the last edge, drive, then book the transfers of the next edge.
    task automatic cycle(input bit v, input logic [31:0] d, input logic [7:0] t,
                         input bit ordy, output bit acc);
        exp_t m;
        @(negedge clk);
        check_outputs();
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_tag    = t;
        bus.out_ready = ordy;
        #1;
        check_eq("in_ready", bus.in_ready, (q.size() < 2) || ordy);
        if (bus.out_valid && ordy && q.size() > 0) void'(q.pop_front());
        acc = v && bus.in_ready;
        if (acc) begin
            m = model(d, t);
            m.due = cyc + 2;
            q.push_back(m);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] t, input bit ordy);
        bit acc = 0;
        for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, d, t, ordy, acc);
        if (!acc) check_eq("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'hDEAD_BEEF, 8'h00, ordy, acc);
    endtask

    initial begin
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_outs", {bus.out_cnt, bus.out_zero, bus.out_data, bus.out_tag}, '0);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;

        // Directed vectors, including latency, zero input and MSB set
        send(32'h0000_0001, 8'hA1, 1'b1);
        idle(3, 1'b1);
        send(32'h0000_0000, 8'hA2, 1'b1);
        send(32'h8000_0000, 8'hA3, 1'b1);
        idle(3, 1'b1);

        // Back-to-back stream: counts 8, 15, 1
        send(32'h00F0_0000, 8'hB1, 1'b1);
        send(32'h0001_2345, 8'hB2, 1'b1);
        send(32'h4000_0000, 8'hB3, 1'b1);
        idle(4, 1'b1);

        // Backpressure: third beat must be refused while both stages are full
        send(32'h0000_00FF, 8'hC1, 1'b0);
        send(32'h0000_0F00, 8'hC2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0010_0000, 8'hC3, 1'b0, acc);
            check_eq("bp_refused", acc, 1'b0);
        end
        send(32'h0010_0000, 8'hC3, 1'b1);
        idle(4, 1'b1);

        // Asynchronous reset with both stages valid
        send(32'h0000_1000, 8'hD1, 1'b0);
        send(32'h0200_0000, 8'hD2, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", bus.out_valid, 1'b0);
        check_eq("arst_outs", {bus.out_cnt, bus.out_zero, bus.out_data, bus.out_tag}, '0);
        check_eq("arst_in_ready", bus.in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(4, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d = $urandom >> $urandom_range(0, 32);
            cycle($urandom_range(0, 3) != 0, d, 8'($urandom), $urandom_range(0, 9) < 7, acc);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 1'b1);
        check_eq("drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
